block_fetch_sched: RTL

BLOCK_FETCH_SCHED -- requirements
Module: block_fetch_sched

---
 rtl/block_fetch_sched_pkg.sv | 34 +++
 rtl/block_fetch_sched_if.sv | 44 ++++
 rtl/block_fetch_sched_assembler.sv | 52 +++++
 rtl/block_fetch_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/block_fetch_sched_pkg.sv
// frame_pkg: frame geometry, address width and scheduler state encoding
// shared by the block fetch scheduler, its interface and the bench.
package frame_pkg;

  localparam int FRAME_W  = 320;
  localparam int FRAME_H  = 240;
  localparam int BLK      = 4;
  localparam int ADDR_W   = 17;
  localparam int BLK_COLS = FRAME_W / BLK;
  localparam int BLK_ROWS = FRAME_H / BLK;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    PRESENT,
    FINISH
  } state_e;

  // Byte address of the top-left pixel of block (x, y).
  function automatic logic [ADDR_W-1:0] blk_base(
    input logic [6:0] x,
    input logic [5:0] y,
    input int         fw,
    input int         b
  );
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] col_step;
    row_step = ADDR_W'(b * fw);
    col_step = ADDR_W'(b);
    return ADDR_W'(y) * row_step + ADDR_W'(x) * col_step;
  endfunction

endpackage

// File: rtl/block_fetch_sched_if.sv
// block_fetch_sched_if: frame-memory read port plus block output stream.
// master = scheduler side, slave = memory / downstream side.
interface block_fetch_sched_if;
  import frame_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata0;
  logic [7:0]        mem_rdata1;
  logic [7:0]        mem_rdata2;
  logic [7:0]        mem_rdata3;

  logic              blk_valid;
  logic              blk_ready;
  logic [31:0]       blk_row0;
  logic [31:0]       blk_row1;
  logic [31:0]       blk_row2;
  logic [31:0]       blk_row3;
  logic [6:0]        blk_x;
  logic [5:0]        blk_y;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata0, mem_rdata1,
    input  mem_rdata2, mem_rdata3,
    output blk_valid,
    input  blk_ready,
    output blk_row0, blk_row1,
    output blk_row2, blk_row3,
    output blk_x, blk_y
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata0, mem_rdata1,
    output mem_rdata2, mem_rdata3,
    input  blk_valid,
    output blk_ready,
    input  blk_row0, blk_row1,
    input  blk_row2, blk_row3,
    input  blk_x, blk_y
  );

endinterface

// File: rtl/block_fetch_sched_assembler.sv
// block_assembler: four 32-bit row registers filled one column per cycle.
// Ports: clk, rst, rd_en/col (read issued this cycle), flush, rdata0..3, row0..3.
module block_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [1:0]  col,
  input  logic        flush,
  input  logic [7:0]  rdata0,
  input  logic [7:0]  rdata1,
  input  logic [7:0]  rdata2,
  input  logic [7:0]  rdata3,
  output logic [31:0] row0,
  output logic [31:0] row1,
  output logic [31:0] row2,
  output logic [31:0] row3
);

  logic [3:0][31:0] rows_q;
  logic [3:0][7:0]  rd;
  logic             en_q;
  logic [1:0]       col_q;
  logic [4:0]       lsb;

  assign rd  = {rdata3, rdata2, rdata1, rdata0};
  // Column 0 lands in the top byte: lsb = 8 * (3 - col).
  assign lsb = {~col_q, 3'b000};

  // Read data trails the strobe by one cycle, so the column tag
  // is delayed to line up with it; flush drops that stray byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q <= '0;
      en_q   <= 1'b0;
      col_q  <= 2'd0;
    end else begin
      en_q  <= rd_en & ~flush;
      col_q <= col;
      if (en_q && !flush) begin
        for (int n = 0; n < 4; n++) begin
          rows_q[n][lsb +: 8] <= rd[n];
        end
      end
    end
  end

  assign row0 = rows_q[0];
  assign row1 = rows_q[1];
  assign row2 = rows_q[2];
  assign row3 = rows_q[3];

endmodule

// File: rtl/block_fetch_sched.sv
// block_fetch_sched: raster scan of BLKxBLK pixel blocks over a frame.
// Ports: clk, rst, start, abort, busy, done; bus = mem read + block stream.
module block_fetch_sched
  import frame_pkg::*;
#(
  parameter int FRAME_W = frame_pkg::FRAME_W,
  parameter int FRAME_H = frame_pkg::FRAME_H,
  parameter int BLK     = frame_pkg::BLK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  block_fetch_sched_if.master bus
);

  localparam int LAST_X = FRAME_W / BLK - 1;
  localparam int LAST_Y = FRAME_H / BLK - 1;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] c_q;
  logic [1:0] c_d;
  logic [6:0] x_q;
  logic [6:0] x_d;
  logic [5:0] y_q;
  logic [5:0] y_d;

  logic              rd_en;
  logic              valid;
  logic              fin;
  logic              kill;
  logic              last_x;
  logic              last_blk;
  logic [ADDR_W-1:0] base;

  assign kill     = abort && (state_q != IDLE);
  assign last_x   = (x_q == 7'(LAST_X));
  assign last_blk = last_x && (y_q == 6'(LAST_Y));
  assign base     = blk_base(x_q, y_q, FRAME_W, BLK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= 2'd0;
      x_q     <= 7'd0;
      y_q     <= 6'd0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    x_d     = x_q;
    y_d     = y_q;
    rd_en   = 1'b0;
    valid   = 1'b0;
    fin     = 1'b0;
    if (kill) begin
      state_d = IDLE;
      c_d     = 2'd0;
      x_d     = 7'd0;
      y_d     = 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            c_d     = 2'd0;
            x_d     = 7'd0;
            y_d     = 6'd0;
          end
        end
        FETCH: begin
          rd_en = 1'b1;
          c_d   = c_q + 2'd1;
          if (c_q == 2'd3) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          state_d = PRESENT;
        end
        PRESENT: begin
          valid = 1'b1;
          if (bus.blk_ready) begin
            c_d = 2'd0;
            if (last_blk) begin
              state_d = FINISH;
            end else if (last_x) begin
              state_d = FETCH;
              x_d     = 7'd0;
              y_d     = y_q + 6'd1;
            end else begin
              state_d = FETCH;
              x_d     = x_q + 7'd1;
            end
          end
        end
        FINISH: begin
          fin     = 1'b1;
          state_d = IDLE;
          x_d     = 7'd0;
          y_d     = 6'd0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = fin;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = (state_q == FETCH)
                       ? base + ADDR_W'(c_q)
                       : '0;
  assign bus.blk_valid = valid;
  assign bus.blk_x     = x_q;
  assign bus.blk_y     = y_q;

  block_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en),
    .col    (c_q),
    .flush  (kill),
    .rdata0 (bus.mem_rdata0),
    .rdata1 (bus.mem_rdata1),
    .rdata2 (bus.mem_rdata2),
    .rdata3 (bus.mem_rdata3),
    .row0   (bus.blk_row0),
    .row1   (bus.blk_row1),
    .row2   (bus.blk_row2),
    .row3   (bus.blk_row3)
  );

endmodule
